// File: rtl/mod_74x163_cascade_pkg.sv
// Shared constants, operation encoding and the priority decoder used by every
// 74x163 slice of the cascaded counter.
package mod_74x163_cascade_pkg;

  localparam int NIBBLE_W = 4;
  localparam logic [NIBBLE_W-1:0] NIBBLE_MAX  = 4'hF;
  localparam logic [NIBBLE_W-1:0] NIBBLE_ZERO = 4'h0;
  localparam logic [NIBBLE_W-1:0] NIBBLE_ONE  = 4'h1;

  // Operation selected for a slice on the next rising edge, highest priority first.
  typedef enum logic [2:0] {
    OP_RST  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_CNT  = 3'd3,
    OP_HOLD = 3'd4
  } op_e;

  // First true condition wins: reset, clear, load, count, otherwise hold.
  function automatic op_e decode_op(
    input logic rst,
    input logic clr_n,
    input logic load_n,
    input logic enp,
    input logic ent
  );
    op_e op;
    if (rst) begin
      op = OP_RST;
    end else if (!clr_n) begin
      op = OP_CLR;
    end else if (!load_n) begin
      op = OP_LOAD;
    end else if (enp && ent) begin
      op = OP_CNT;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/mod_74x163_cascade_if.sv
// Control/data bundle of the cascaded counter. The master side drives the
// clear/load/enable controls and load data; the slave (the counter) returns
// the count and the ripple carry.
interface mod_74x163_cascade_if #(
  parameter int WIDTH = 4
);

  logic             CLR_N;
  logic             LOAD_N;
  logic             ENP;
  logic             ENT;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             RCO;

  modport master (
    output CLR_N,
    output LOAD_N,
    output ENP,
    output ENT,
    output D,
    input  Q,
    input  RCO
  );

  modport slave (
    input  CLR_N,
    input  LOAD_N,
    input  ENP,
    input  ENT,
    input  D,
    output Q,
    output RCO
  );

endinterface

// File: rtl/mod_74x163_cascade_slice.sv
// One 4-bit 74x163 synchronous presettable counter with an added synchronous
// active-high system reset. RCO is combinational so a cascade carries within
// the same cycle.
module mod_74x163_cascade_slice
  import mod_74x163_cascade_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                CLR_N,
  input  logic                LOAD_N,
  input  logic                ENP,
  input  logic                ENT,
  input  logic [NIBBLE_W-1:0] D,
  output logic [NIBBLE_W-1:0] Q,
  output logic                RCO
);

  op_e                 op_s;
  logic [NIBBLE_W-1:0] q_next_s;
  logic [NIBBLE_W-1:0] q_r;

  // Pick the operation for this edge and compute the next nibble value.
  always_comb begin
    op_s     = decode_op(RST, CLR_N, LOAD_N, ENP, ENT);
    q_next_s = q_r;
    case (op_s)
      OP_RST:  q_next_s = NIBBLE_ZERO;
      OP_CLR:  q_next_s = NIBBLE_ZERO;
      OP_LOAD: q_next_s = D;
      OP_CNT:  q_next_s = q_r + NIBBLE_ONE;
      OP_HOLD: q_next_s = q_r;
      default: q_next_s = NIBBLE_ZERO;
    endcase
  end

  // Nibble state register; reset is folded into the next-state decode.
  always_ff @(posedge CLK) begin
    q_r <= q_next_s;
  end

  assign Q   = q_r;
  assign RCO = ENT & (q_r == NIBBLE_MAX);

endmodule

// File: rtl/mod_74x163_cascade.sv
// Synchronous presettable binary counter built from STAGES cascaded 74x163
// slices. ENP fans out to every slice; ENT enters slice 0 and each slice's
// RCO becomes the ENT of the next, so the top RCO is ENT & (Q == all ones).
module mod_74x163_cascade
  import mod_74x163_cascade_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  mod_74x163_cascade_if.slave   bus
);

  localparam int WIDTH = NIBBLE_W * STAGES;

  logic [STAGES:0]  ent_chain_s;
  logic [WIDTH-1:0] q_s;

  assign ent_chain_s[0] = bus.ENT;

  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    mod_74x163_cascade_slice u_slice (
      .CLK    (CLK),
      .RST    (RST),
      .CLR_N  (bus.CLR_N),
      .LOAD_N (bus.LOAD_N),
      .ENP    (bus.ENP),
      .ENT    (ent_chain_s[i]),
      .D      (bus.D[NIBBLE_W*i +: NIBBLE_W]),
      .Q      (q_s[NIBBLE_W*i +: NIBBLE_W]),
      .RCO    (ent_chain_s[i+1])
    );
  end

  assign bus.Q   = q_s;
  assign bus.RCO = ent_chain_s[STAGES];

endmodule
